// File: rtl/radar_multi_ch_monitor.sv
// Multi-channel radar distance monitor: per-channel sample latch, debounced proximity
// alarm with hysteresis, stale detection, and manual/auto-scan display selection.
module radar_multi_ch_monitor #(
  parameter int N_CH      = 4,
  parameter int DW        = 20,
  parameter int MIN_TH    = 3,
  parameter int NEAR_TH   = 35,
  parameter int HYST      = 2,
  parameter int ALM_CNT   = 3,
  parameter int STALE_CYC = 50_000_000,
  parameter int SCAN_CYC  = 100_000_000,
  parameter int CW        = $clog2(N_CH)
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  input  logic [N_CH*DW-1:0] i_jl_data,
  input  logic [N_CH-1:0]    i_jl_vld,
  input  logic               i_key_next,
  input  logic               i_mode_auto,
  output logic [23:0]        o_show_data,
  output logic [CW-1:0]      o_show_ch,
  output logic [N_CH-1:0]    o_alarm,
  output logic               o_alarm_any,
  output logic [N_CH-1:0]    o_stale,
  output logic [2*N_CH-1:0]  o_dbg_alm_state
);

  typedef enum logic [1:0] {
    ST_SAFE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALARM = 2'd2
  } alm_state_t;

  localparam int SW = $clog2(STALE_CYC + 1);
  localparam int HW = $clog2(ALM_CNT + 1);
  localparam int TW = $clog2(SCAN_CYC + 1);

  localparam logic [DW-1:0] MIN_V     = DW'(MIN_TH);
  localparam logic [DW-1:0] NEAR_V    = DW'(NEAR_TH);
  localparam logic [DW-1:0] REL_V     = DW'(NEAR_TH + HYST);
  localparam logic [HW-1:0] ALM_V     = HW'(ALM_CNT);
  localparam logic [SW-1:0] STALE_V   = SW'(STALE_CYC);
  localparam logic [TW-1:0] SCAN_LAST = TW'(SCAN_CYC - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(N_CH - 1);

  logic [N_CH*DW-1:0] dist_flat;
  logic [N_CH-1:0]    alarm_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DW-1:0] smp;
    logic [DW-1:0] dist_r;
    logic          vld;
    logic          in_win;
    logic          rel;
    alm_state_t    st_q, st_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          stale_q, stale_d;

    assign smp    = i_jl_data[k*DW +: DW];
    assign vld    = i_jl_vld[k];
    assign in_win = (smp > MIN_V) && (smp < NEAR_V);
    assign rel    = (smp >= REL_V) || (smp <= MIN_V);

    // Stale flag is sticky until the next sample so a never-fed channel stays stale.
    always_comb begin
      scnt_d  = scnt_q;
      stale_d = stale_q;
      if (vld) begin
        scnt_d  = '0;
        stale_d = 1'b0;
      end else begin
        if (scnt_q != STALE_V) scnt_d = scnt_q + SW'(1);
        if (scnt_d == STALE_V) stale_d = 1'b1;
      end
    end

    always_comb begin
      st_d  = st_q;
      hit_d = hit_q;
      if (vld) begin
        case (st_q)
          ST_SAFE: begin
            if (in_win) begin
              if (ALM_CNT == 1) begin
                st_d  = ST_ALARM;
                hit_d = '0;
              end else begin
                st_d  = ST_PEND;
                hit_d = HW'(1);
              end
            end
          end
          ST_PEND: begin
            if (in_win) begin
              hit_d = hit_q + HW'(1);
              if (hit_d == ALM_V) begin
                st_d  = ST_ALARM;
                hit_d = '0;
              end
            end else begin
              st_d  = ST_SAFE;
              hit_d = '0;
            end
          end
          ST_ALARM: begin
            if (rel) st_d = ST_SAFE;
          end
          default: begin
            st_d  = ST_SAFE;
            hit_d = '0;
          end
        endcase
      end else if (stale_d) begin
        st_d  = ST_SAFE;
        hit_d = '0;
      end
    end

    always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
        st_q    <= ST_SAFE;
        hit_q   <= '0;
        scnt_q  <= '0;
        stale_q <= 1'b1;
        dist_r  <= '0;
      end else begin
        st_q    <= st_d;
        hit_q   <= hit_d;
        scnt_q  <= scnt_d;
        stale_q <= stale_d;
        if (vld) dist_r <= smp;
      end
    end

    assign dist_flat[k*DW +: DW]    = dist_r;
    assign alarm_d[k]               = (st_d == ST_ALARM);
    assign o_alarm[k]               = (st_q == ST_ALARM);
    assign o_stale[k]               = stale_q;
    assign o_dbg_alm_state[2*k +: 2] = st_q;
  end

  logic [CW-1:0] low_ch;
  logic [CW-1:0] nxt_ch;
  logic [DW-1:0] sel_dist;
  logic [19:0]   show_dist;
  logic [TW-1:0] dwell_q;
  logic          mode_q;

  always_comb begin
    low_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (o_alarm[i]) low_ch = CW'(i);
    end
  end

  assign nxt_ch    = (o_show_ch == LAST_CH) ? '0 : o_show_ch + CW'(1);
  assign sel_dist  = dist_flat[o_show_ch*DW +: DW];
  assign show_dist = o_stale[o_show_ch] ? 20'hFFFFF : 20'(sel_dist);

  // A mode change only restarts the dwell; alarm override and key steps resume next cycle.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      o_show_ch   <= '0;
      o_show_data <= '0;
      o_alarm_any <= 1'b0;
      dwell_q     <= '0;
      mode_q      <= 1'b0;
    end else begin
      mode_q      <= i_mode_auto;
      o_alarm_any <= |alarm_d;
      o_show_data <= {4'(o_show_ch), show_dist};
      if (i_mode_auto != mode_q) begin
        dwell_q <= '0;
      end else if (i_mode_auto) begin
        if (o_alarm_any) begin
          o_show_ch <= low_ch;
          dwell_q   <= '0;
        end else if (dwell_q == SCAN_LAST) begin
          o_show_ch <= nxt_ch;
          dwell_q   <= '0;
        end else begin
          dwell_q <= dwell_q + TW'(1);
        end
      end else begin
        dwell_q <= '0;
        if (i_key_next) o_show_ch <= nxt_ch;
      end
    end
  end

endmodule

// File: tb/tb_radar_multi_ch_monitor.sv
// Bench for radar_multi_ch_monitor: directed scenarios plus random traffic, every cycle
// compared against a behavioural model built from integer counters and flags.
module tb_radar_multi_ch_monitor;

  localparam int N_CH      = 4;
  localparam int DW        = 20;
  localparam int MIN_TH    = 3;
  localparam int NEAR_TH   = 35;
  localparam int HYST      = 2;
  localparam int ALM_CNT   = 3;
  localparam int STALE_CYC = 100;
  localparam int SCAN_CYC  = 8;
  localparam int CW        = $clog2(N_CH);

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH*DW-1:0] jl_data;
  logic [N_CH-1:0]    jl_vld;
  logic               key;
  logic               mode;
  logic [23:0]        show_data;
  logic [CW-1:0]      show_ch;
  logic [N_CH-1:0]    alarm;
  logic               alarm_any;
  logic [N_CH-1:0]    stale;
  logic [2*N_CH-1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  radar_multi_ch_monitor #(
    .N_CH(N_CH), .DW(DW), .MIN_TH(MIN_TH), .NEAR_TH(NEAR_TH), .HYST(HYST),
    .ALM_CNT(ALM_CNT), .STALE_CYC(STALE_CYC), .SCAN_CYC(SCAN_CYC), .CW(CW)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .i_jl_data(jl_data),
    .i_jl_vld(jl_vld),
    .i_key_next(key),
    .i_mode_auto(mode),
    .o_show_data(show_data),
    .o_show_ch(show_ch),
    .o_alarm(alarm),
    .o_alarm_any(alarm_any),
    .o_stale(stale),
    .o_dbg_alm_state(dbg_state)
  );

  // reference model
  int          m_dist[N_CH];
  int          m_hits[N_CH];
  bit          m_alm[N_CH];
  int          m_silent[N_CH];
  bit          m_stl[N_CH];
  int          m_ch;
  int          m_dwell;
  bit          m_mode_prev;
  bit          m_any;
  logic [23:0] m_show;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_dist[k] = 0; m_hits[k] = 0; m_alm[k] = 0; m_silent[k] = 0; m_stl[k] = 1;
    end
    m_ch = 0; m_dwell = 0; m_mode_prev = 0; m_any = 0; m_show = 24'h0;
  endtask

  task automatic model_update();
    int  lowest;
    int  d;
    logic [19:0] fld;
    if (rst) begin
      model_reset();
      return;
    end
    // display uses the pre-edge channel, distance and stale flag
    fld = m_stl[m_ch] ? 20'hFFFFF : 20'(m_dist[m_ch]);
    m_show = {4'(m_ch), fld};
    lowest = -1;
    for (int k = N_CH - 1; k >= 0; k--) if (m_alm[k]) lowest = k;
    if (mode != m_mode_prev) begin
      m_dwell = 0;
    end else if (mode) begin
      if (m_any) begin
        m_ch = lowest; m_dwell = 0;
      end else if (m_dwell == SCAN_CYC - 1) begin
        m_dwell = 0; m_ch = (m_ch + 1) % N_CH;
      end else begin
        m_dwell++;
      end
    end else begin
      m_dwell = 0;
      if (key) m_ch = (m_ch + 1) % N_CH;
    end
    m_mode_prev = mode;
    for (int k = 0; k < N_CH; k++) begin
      if (jl_vld[k]) begin
        d = int'(jl_data[k*DW +: DW]);
        m_dist[k] = d; m_silent[k] = 0; m_stl[k] = 0;
        if (m_alm[k]) begin
          if (d >= NEAR_TH + HYST || d <= MIN_TH) begin
            m_alm[k] = 0; m_hits[k] = 0;
          end
        end else if (d > MIN_TH && d < NEAR_TH) begin
          m_hits[k]++;
          if (m_hits[k] >= ALM_CNT) begin
            m_alm[k] = 1; m_hits[k] = 0;
          end
        end else begin
          m_hits[k] = 0;
        end
      end else begin
        if (m_silent[k] < STALE_CYC) m_silent[k]++;
        if (m_silent[k] == STALE_CYC) m_stl[k] = 1;
        if (m_stl[k]) begin
          m_alm[k] = 0; m_hits[k] = 0;
        end
      end
    end
    m_any = 0;
    for (int k = 0; k < N_CH; k++) m_any |= m_alm[k];
  endtask

  task automatic compare_all();
    logic [N_CH-1:0] ea, es;
    for (int k = 0; k < N_CH; k++) begin
      ea[k] = m_alm[k]; es[k] = m_stl[k];
    end
    check("alarm", 32'(alarm), 32'(ea));
    check("alarm_any", 32'(alarm_any), 32'(m_any));
    check("stale", 32'(stale), 32'(es));
    check("show_ch", 32'(show_ch), 32'(m_ch));
    check("show_data", 32'(show_data), 32'(m_show));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic set_d(input int ch, input int d);
    jl_data[ch*DW +: DW] = DW'(d);
  endtask

  task automatic sample(input int ch, input int d);
    set_d(ch, d);
    jl_vld = '0;
    jl_vld[ch] = 1'b1;
    step();
    jl_vld = '0;
  endtask

  task automatic sample2(input int ch_a, input int ch_b, input int d);
    set_d(ch_a, d);
    set_d(ch_b, d);
    jl_vld = '0;
    jl_vld[ch_a] = 1'b1;
    jl_vld[ch_b] = 1'b1;
    step();
    jl_vld = '0;
  endtask

  task automatic press_key();
    key = 1'b1;
    step();
    key = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int rate;
    rst = 1'b1; jl_data = '0; jl_vld = '0; key = 1'b0; mode = 1'b0;
    model_reset();
    idle(2);
    check("rst_alarm", 32'(alarm), 32'h0);
    check("rst_stale", 32'(stale), 32'hF);
    check("rst_show_data", 32'(show_data), 32'h0);
    check("rst_show_ch", 32'(show_ch), 32'h0);
    rst = 1'b0;

    // debounce on ch1, PEND fallback on ch3
    sample(1, 20);
    sample(1, 20);
    check("dbn_two_samples", 32'(alarm), 32'h0);
    sample(1, 20);
    check("dbn_third_alarm", 32'(alarm), 32'h2);
    check("dbn_third_any", 32'(alarm_any), 32'h1);
    sample(3, 20);
    sample(3, 2);
    sample(3, 20);
    sample(3, 20);
    check("pend_reset_hits", 32'(alarm[3]), 32'h0);

    // hysteresis on ch0
    sample(0, 20); sample(0, 20); sample(0, 20);
    check("hys_raise", 32'(alarm[0]), 32'h1);
    sample(0, 35);
    check("hys_35", 32'(alarm[0]), 32'h1);
    sample(0, 36);
    check("hys_36", 32'(alarm[0]), 32'h1);
    sample(0, 37);
    check("hys_37", 32'(alarm[0]), 32'h0);

    // mid-alarm reset
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst2_alarm", 32'(alarm), 32'h0);
    check("rst2_stale", 32'(stale), 32'hF);
    check("rst2_show_data", 32'(show_data), 32'h0);

    // stale on ch2 while displayed
    press_key(); press_key();
    sample(2, 20); sample(2, 20); sample(2, 20);
    check("stl_alarm_on", 32'(alarm[2]), 32'h1);
    idle(99);
    check("stl_not_yet", 32'(stale[2]), 32'h0);
    check("stl_show_live", 32'(show_data), 32'h200014);
    step();
    check("stl_set", 32'(stale[2]), 32'h1);
    check("stl_alarm_drop", 32'(alarm[2]), 32'h0);
    step();
    check("stl_show", 32'(show_data), 32'h2FFFFF);
    sample(2, 10);
    check("stl_clear", 32'(stale[2]), 32'h0);
    check("stl_clear_alarm", 32'(alarm[2]), 32'h0);

    // manual wrap
    press_key();
    check("wrap_3", 32'(show_ch), 32'h3);
    press_key();
    check("wrap_0", 32'(show_ch), 32'h0);
    press_key();
    check("wrap_1", 32'(show_ch), 32'h1);
    press_key();
    check("wrap_2", 32'(show_ch), 32'h2);

    // auto mode: key ignored, scan every SCAN_CYC cycles
    mode = 1'b1;
    step();
    press_key();
    check("auto_key_ignored", 32'(show_ch), 32'h2);
    idle(6);
    check("scan_hold", 32'(show_ch), 32'h2);
    step();
    check("scan_adv", 32'(show_ch), 32'h3);
    idle(8);
    check("scan_wrap", 32'(show_ch), 32'h0);

    // alarm override: lowest alarmed channel wins, then falls back
    sample2(3, 1, 20); sample2(3, 1, 20); sample2(3, 1, 20);
    check("ovr_alarms", 32'(alarm), 32'hA);
    step();
    check("ovr_ch1", 32'(show_ch), 32'h1);
    idle(20);
    check("ovr_hold", 32'(show_ch), 32'h1);
    sample(1, 40);
    step();
    check("ovr_ch3", 32'(show_ch), 32'h3);
    sample(3, 50);
    idle(3);
    check("ovr_resume", 32'(show_ch), 32'h3);

    // random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rate = (cyc / 500) % 4;
      rst = ($urandom_range(0, 999) == 0);
      for (int k = 0; k < N_CH; k++) begin
        set_d(k, $urandom_range(0, 45));
        case (rate)
          0:       jl_vld[k] = ($urandom_range(0, 3) == 0);
          1:       jl_vld[k] = ($urandom_range(0, 29) == 0);
          2:       jl_vld[k] = ($urandom_range(0, 149) == 0);
          default: jl_vld[k] = ($urandom_range(0, 1) == 0);
        endcase
      end
      key = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      step();
    end
    rst = 1'b0; jl_vld = '0; key = 1'b0;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
